// File: rtl/cache_profiler.sv
// Direct-mapped cache hit/miss profiler: tag store lookup, counters, flush.
// Ports: clk_i, rst_i (async low), access_valid_i/addr_i/write_i, clear_i,
// busy_o, hit_o, miss_o, access_count_o, hit_count_o.
// Optional build macro: CACHE_PROFILER_WRITE_NO_ALLOCATE_EN (no allocate on write misses).
module cache_profiler #(
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS  = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        access_valid_i,
  input  logic [31:0] addr_i,
  input  logic        write_i,
  input  logic        clear_i,
  output logic        busy_o,
  output logic        hit_o,
  output logic        miss_o,
  output logic [31:0] access_count_o,
  output logic [31:0] hit_count_o
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - OFFSET_BITS - INDEX_BITS;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state_q, state_n;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tags_q [LINES];
  logic [INDEX_BITS-1:0] ptr_q;
  logic [31:0]           acc_q;
  logic [31:0]           hit_q;
  logic                  hit_pq;
  logic                  miss_pq;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  accept;
  logic                  hit;
  logic                  alloc;
  logic                  do_clear;

  assign idx = addr_i[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign tag = addr_i[31:OFFSET_BITS+INDEX_BITS];

  assign accept   = access_valid_i && (state_q == IDLE) && !clear_i;
  assign do_clear = (state_q == IDLE) && clear_i;
  assign hit      = valid_q[idx] && (tags_q[idx] == tag);

`ifdef CACHE_PROFILER_WRITE_NO_ALLOCATE_EN
  assign alloc = accept && !hit && !write_i;
`else
  assign alloc = accept && !hit;
`endif

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (clear_i) state_n = FLUSH;
      FLUSH:   if (ptr_q == '1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == FLUSH) begin
        valid_q[ptr_q] <= 1'b0;
        ptr_q          <= ptr_q + INDEX_BITS'(1);
      end else if (alloc) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Tag array carries no reset; valid bits alone qualify its contents.
  always_ff @(posedge clk_i) begin
    if (alloc) tags_q[idx] <= tag;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_pq  <= 1'b0;
      miss_pq <= 1'b0;
      acc_q   <= '0;
      hit_q   <= '0;
    end else begin
      hit_pq  <= accept && hit;
      miss_pq <= accept && !hit;
      if (do_clear) begin
        acc_q <= '0;
        hit_q <= '0;
      end else if (accept) begin
        if (acc_q != '1) acc_q <= acc_q + 32'd1;
        if (hit && (hit_q != '1)) hit_q <= hit_q + 32'd1;
      end
    end
  end

  assign busy_o         = (state_q == FLUSH);
  assign hit_o          = hit_pq;
  assign miss_o         = miss_pq;
  assign access_count_o = acc_q;
  assign hit_count_o    = hit_q;

endmodule

// File: tb/tb_cache_profiler.sv
// Directed self-checking bench for cache_profiler.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_cache_profiler;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        access_valid_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        write_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        busy_o;
  logic        hit_o;
  logic        miss_o;
  logic [31:0] access_count_o;
  logic [31:0] hit_count_o;

  int total  = 0;
  int passed = 0;
  int n;

  cache_profiler dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .access_valid_i (access_valid_i),
    .addr_i         (addr_i),
    .write_i        (write_i),
    .clear_i        (clear_i),
    .busy_o         (busy_o),
    .hit_o          (hit_o),
    .miss_o         (miss_o),
    .access_count_o (access_count_o),
    .hit_count_o    (hit_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tg, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic access(input logic [31:0] a, input logic w);
    access_valid_i = 1'b1;
    addr_i         = a;
    write_i        = w;
    tick();
    access_valid_i = 1'b0;
    write_i        = 1'b0;
  endtask

  task automatic hm(input string tg, input logic eh, input logic em);
    chk({tg, "_hit"}, {31'd0, hit_o}, {31'd0, eh});
    chk({tg, "_miss"}, {31'd0, miss_o}, {31'd0, em});
  endtask

  task automatic cnt(input string tg, input logic [31:0] ea,
                     input logic [31:0] eh);
    chk({tg, "_acc"}, access_count_o, ea);
    chk({tg, "_hits"}, hit_count_o, eh);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state while rst_i is held low
    #2;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    hm("rst", 1'b0, 1'b0);
    cnt("rst", 32'd0, 32'd0);
    tick();
    rst_i = 1'b1;
    tick();

    // Same line twice back to back: miss then hit
    access(32'h40, 1'b0);
    hm("b2b1", 1'b0, 1'b1);
    access(32'h40, 1'b0);
    hm("b2b2", 1'b1, 1'b0);
    cnt("b2b", 32'd2, 32'd1);
    tick();
    hm("idle", 1'b0, 1'b0);

    // Conflict on index 4
    do_reset();
    access(32'h40, 1'b0);
    hm("cf1", 1'b0, 1'b1);
    access(32'h440, 1'b0);
    hm("cf2", 1'b0, 1'b1);
    access(32'h40, 1'b0);
    hm("cf3", 1'b0, 1'b1);
    cnt("cf", 32'd3, 32'd0);

    // Three hits, then clear with a coincident access
    access(32'h40, 1'b0);
    access(32'h40, 1'b0);
    access(32'h40, 1'b0);
    hm("pre_clr", 1'b1, 1'b0);
    cnt("pre_clr", 32'd6, 32'd3);
    clear_i        = 1'b1;
    access_valid_i = 1'b1;
    addr_i         = 32'h40;
    tick();
    clear_i = 1'b0;
    chk("clr_busy", {31'd0, busy_o}, 32'd1);
    hm("clr", 1'b0, 1'b0);
    cnt("clr", 32'd0, 32'd0);
    // access_valid_i stays high through the flush; all dropped
    n = 1;
    for (int i = 0; i < 200; i++) begin
      if (n == 10) clear_i = 1'b1;
      else clear_i = 1'b0;
      tick();
      if (busy_o) n++;
      else break;
    end
    clear_i        = 1'b0;
    access_valid_i = 1'b0;
    chk("busy_len", n, 32'd64);
    hm("flush_drop", 1'b0, 1'b0);
    cnt("flush_drop", 32'd0, 32'd0);
    access(32'h40, 1'b0);
    hm("post_flush", 1'b0, 1'b1);
    cnt("post_flush", 32'd1, 32'd0);

    // Write miss followed by read of the same address
    do_reset();
    access(32'h100, 1'b1);
    hm("wr", 1'b0, 1'b1);
    access(32'h100, 1'b0);
`ifdef CACHE_PROFILER_WRITE_NO_ALLOCATE_EN
    hm("rd_after_wr", 1'b0, 1'b1);
    cnt("wr", 32'd2, 32'd0);
`else
    hm("rd_after_wr", 1'b1, 1'b0);
    cnt("wr", 32'd2, 32'd1);
`endif
    access(32'h100, 1'b0);
    access(32'h100, 1'b1);
    hm("wr_hit", 1'b1, 1'b0);

    // Reset in cycle 10 of a flush
    do_reset();
    access(32'h40, 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    cnt("mid_rst", 32'd0, 32'd0);
    hm("mid_rst", 1'b0, 1'b0);
    tick();
    rst_i = 1'b1;
    tick();
    access(32'h40, 1'b0);
    hm("after_rst", 1'b0, 1'b1);
    cnt("after_rst", 32'd1, 32'd0);

    // Saturation
    access(32'h40, 1'b0);
    force dut.acc_q = 32'hFFFF_FFFE;
    force dut.hit_q = 32'hFFFF_FFFE;
    #1;
    release dut.acc_q;
    release dut.hit_q;
    access(32'h40, 1'b0);
    access(32'h40, 1'b0);
    access(32'h40, 1'b0);
    hm("sat", 1'b1, 1'b0);
    cnt("sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_profiler.md
CACHE_PROFILER -- requirements
Module: cache_profiler

Interface
REQ-001 SHALL have parameter OFFSET_BITS, default 4, byte-offset bits per block (16-byte blocks).
REQ-002 SHALL have parameter INDEX_BITS, default 6, line-index bits (64 lines, direct-mapped).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port access_valid_i, input, 1, an address is presented this cycle.
REQ-006 SHALL have port addr_i, input, 32, byte address of the access.
REQ-007 SHALL have port write_i, input, 1, access is a store (qualified by access_valid_i).
REQ-008 SHALL have port clear_i, input, 1, request flush of tag store and counters.
REQ-009 SHALL have port busy_o, output, 1, flush in progress; accesses ignored.
REQ-010 SHALL have port hit_o, output, 1, one-cycle pulse: previous accepted access hit.
REQ-011 SHALL have port miss_o, output, 1, one-cycle pulse: previous accepted access missed.
REQ-012 SHALL have port access_count_o, output, 32, accepted accesses since reset/clear.
REQ-013 SHALL have port hit_count_o, output, 32, hits since reset/clear.

Function
REQ-014 SHALL decompose addr_i as index = addr_i[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], tag = addr_i[31:OFFSET_BITS+INDEX_BITS].
REQ-015 SHALL hold per line one valid bit and one tag (32-OFFSET_BITS-INDEX_BITS bits).
REQ-016 SHALL implement FSM states IDLE and FLUSH; IDLE->FLUSH on clear_i; FLUSH->IDLE after the last line is cleared.
REQ-017 SHALL accept an access only when access_valid_i=1, state=IDLE and clear_i=0.
REQ-018 SHALL classify an accepted access as a hit iff the indexed line is valid and its tag equals the address tag.
REQ-019 SHALL assert exactly one of hit_o or miss_o in the cycle after an accepted access; both 0 otherwise.
REQ-020 SHALL, on an allocating miss, write tag and set valid at the same edge that registers miss_o.
REQ-021 SHALL make a line update visible to an access in the immediately following cycle (back-to-back same-line access: miss then hit).
REQ-022 SHALL increment access_count_o per accepted access and hit_count_o per hit, at the edge registering hit_o/miss_o.
REQ-023 SHALL saturate both counters at 32'hFFFFFFFF (no wrap).
REQ-024 SHALL, on the edge where clear_i is sampled in IDLE, zero both counters, enter FLUSH and assert busy_o from the next cycle.
REQ-025 SHALL, in FLUSH, clear one valid bit per cycle from line 0 upward; FLUSH lasts exactly 2^INDEX_BITS cycles.
REQ-026 SHALL ignore clear_i while in FLUSH (no restart).
REQ-027 SHALL drop (not count, not classify) an access coincident with clear_i in IDLE or presented during FLUSH.
REQ-028 SHALL deassert busy_o in the first IDLE cycle after FLUSH; accesses are accepted from that cycle.

Reset
REQ-029 SHALL, while rst_i=0, immediately force state=IDLE, all valid bits=0, flush pointer=0, busy_o=0, hit_o=0, miss_o=0, access_count_o=0, hit_count_o=0.
REQ-030 SHALL abort a flush in progress on reset; tag contents need not be reset.

Configuration
REQ-031 SHALL, with macro CACHE_PROFILER_WRITE_NO_ALLOCATE_EN defined, not allocate on write misses (line unchanged; write hits still counted as hits).
REQ-032 SHALL, without CACHE_PROFILER_WRITE_NO_ALLOCATE_EN, allocate on every miss regardless of write_i.

Verification
REQ-033 SHALL cover: after reset, access 0x00000040 twice in consecutive cycles -> miss_o then hit_o; access_count_o=2, hit_count_o=1.
REQ-034 SHALL cover: access 0x00000040 then 0x00000440 (same index 4, different tag) then 0x00000040 -> miss, miss, miss; hit_count_o=0.
REQ-035 SHALL cover: clear_i pulse after 3 hits -> counters 0 next cycle, busy_o high for exactly 64 cycles, access during busy dropped, next 0x00000040 misses.
REQ-036 SHALL cover: write_i=1 miss at 0x00000100 then read 0x00000100 -> miss, hit without macro; miss, miss with CACHE_PROFILER_WRITE_NO_ALLOCATE_EN.
REQ-037 SHALL cover: rst_i low mid-flush (cycle 10 of FLUSH) -> busy_o=0 and counters 0 immediately; first access after release misses.
REQ-038 SHALL cover: preload counters near saturation (force to 32'hFFFFFFFE), three hits -> both counters read 32'hFFFFFFFF.
